pc_gen: RTL and testbench

Parametrised program-counter generator for the fetch stage; successor to the single-register PC with a hit-gated load. It holds the fetch PC and chooses the next PC by fixed priority: reset, exception, redirect, return prediction, sequential step. An optional return-address stack (RAS) supplies predicted targets for returns. It sits between the branch/exception logic and the instruction cache, and stalls on cache miss (`hit` low).

---
 rtl/pc_pkg.sv | 28 ++
 rtl/pc_ras.sv | 71 +++++++
 rtl/pc_gen.sv | 153 +++++++++++++++
 tb/tb_pc_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared constants and types for the fetch-stage program
//                counter generator (pc_gen) and its return-address stack.
//                - c_reset_vec / c_exc_vec / c_step : default vectors and step
//                - c_ras_depth                      : default RAS depth
//                - pc_sel_e                         : next-PC source select
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    localparam logic [31:0] c_reset_vec = 32'h0000_0000;
    localparam logic [31:0] c_exc_vec   = 32'h0000_0080;
    localparam int unsigned c_step      = 4;
    localparam int unsigned c_ras_depth = 4;

    // Next-PC source, listed from lowest to highest priority.
    typedef enum logic [2:0] {
        SEL_HOLD  = 3'd0,
        SEL_SEQ   = 3'd1,
        SEL_RAS   = 3'd2,
        SEL_REDIR = 3'd3,
        SEL_EXC   = 3'd4
    } pc_sel_e;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
//  Module      : pc_ras
//  Description : Circular return-address stack. Push writes at the pointer
//                and advances it; pop retreats it. When full, a push
//                overwrites the oldest entry and the count saturates.
//                Push and pop together replace the top entry in place.
//                State updates on the falling edge of clk.
//  Ports       : clk, rst        - clock (falling edge), async high reset
//                push, push_data - push request and the address to push
//                pop             - pop request (ignored while empty)
//                top             - current top-of-stack entry
//                count           - number of valid entries (0..DEPTH)
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = c_ras_depth
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] c_full = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_ptr;      // next free slot
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    w_top_idx;
    logic             w_do_pop;

    assign w_top_idx = r_ptr - PW'(1);
    assign w_do_pop  = pop && (r_count != '0);
    assign top       = r_mem[w_top_idx];
    assign count     = r_count;

    // Storage carries no reset; its contents are meaningless while count is 0.
    // A simultaneous pop+push lands on the current top slot instead of the
    // free slot, which is what makes the pair behave as "replace top".
    always_ff @(negedge clk) begin
        if (push) begin
            r_mem[w_do_pop ? w_top_idx : r_ptr] <= push_data;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (push && !w_do_pop) begin
            r_ptr <= r_ptr + PW'(1);   // wraps modulo DEPTH (power of two)
            if (r_count != c_full) begin
                r_count <= r_count + CW'(1);
            end
        end else if (w_do_pop && !push) begin
            r_ptr   <= w_top_idx;
            r_count <= r_count - CW'(1);
        end
    end

endmodule : pc_ras
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen
//  Description : Fetch-stage program counter generator. Next PC is chosen
//                by priority: exception, redirect, RAS return prediction,
//                sequential step, hold (cache miss). State updates on the
//                falling edge of clk; rst is asynchronous active-high.
//                Build option: define PC_RAS_EN to include the return-
//                address stack; without it ras_count and ret_miss read 0,
//                call is ignored and ret is a plain sequential advance.
//  Ports       : clk, rst                   - clock, async reset
//                hit                        - fetch accepted
//                exception                  - trap, loads EXC_VEC
//                redirect_valid/_target     - resolved redirect
//                call, ret                  - fetched insn is call/return
//                pc, pc_plus                - fetch PC and pc + STEP
//                ras_count                  - valid RAS entries
//                ret_miss                   - return taken with empty RAS
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(c_reset_vec),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(c_exc_vec),
    parameter int unsigned      STEP      = c_step,
    parameter int unsigned      RAS_DEPTH = c_ras_depth
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          hit,
    input  logic                          exception,
    input  logic                          redirect_valid,
    input  logic [WIDTH-1:0]              redirect_target,
    input  logic                          call,
    input  logic                          ret,
    output logic [WIDTH-1:0]              pc,
    output logic [WIDTH-1:0]              pc_plus,
    output logic [$clog2(RAS_DEPTH):0]    ras_count,
    output logic                          ret_miss
);

    localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_plus;
    logic [WIDTH-1:0] w_pc_next;
    pc_sel_e          w_sel;

    // Modulo 2^WIDTH by construction; wrap-around raises no flag.
    assign w_pc_plus = r_pc + WIDTH'(STEP);
    assign pc        = r_pc;
    assign pc_plus   = w_pc_plus;

`ifdef PC_RAS_EN
    logic             w_push;
    logic             w_pop;
    logic             w_miss;
    logic [WIDTH-1:0] w_ras_top;
    logic [CW-1:0]    w_ras_count;
    logic             r_ret_miss;

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_plus),
        .top       (w_ras_top),
        .count     (w_ras_count)
    );

    assign ras_count = w_ras_count;
    assign ret_miss  = r_ret_miss;
`else
    logic w_unused_ras;

    assign w_unused_ras = call | ret;
    assign ras_count    = '0;
    assign ret_miss     = 1'b0;
`endif

    // Source selection. Exception and redirect override the cache-miss
    // stall and suppress any call/ret side effects on the stack.
    always_comb begin
        w_sel  = SEL_HOLD;
`ifdef PC_RAS_EN
        w_push = 1'b0;
        w_pop  = 1'b0;
        w_miss = 1'b0;
`endif
        if (exception) begin
            w_sel = SEL_EXC;
        end else if (redirect_valid) begin
            w_sel = SEL_REDIR;
        end else if (hit) begin
            w_sel = SEL_SEQ;
`ifdef PC_RAS_EN
            // A call in the same cycle as a return still pushes; the stack
            // turns pop+push into a top replacement, or a plain push when
            // the return found it empty.
            w_push = call;
            if (ret) begin
                if (w_ras_count != '0) begin
                    w_sel = SEL_RAS;
                    w_pop = 1'b1;
                end else begin
                    w_miss = 1'b1;
                end
            end
`endif
        end
    end

    always_comb begin
        w_pc_next = r_pc;
        case (w_sel)
            SEL_EXC:   w_pc_next = EXC_VEC;
            SEL_REDIR: w_pc_next = redirect_target;
`ifdef PC_RAS_EN
            SEL_RAS:   w_pc_next = w_ras_top;
`endif
            SEL_SEQ:   w_pc_next = w_pc_plus;
            default:   w_pc_next = r_pc;
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_VEC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

`ifdef PC_RAS_EN
    // Registered pulse: follows the select decision each edge, so it is
    // high for exactly one cycle after a return that found the stack empty.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_ret_miss <= 1'b0;
        end else begin
            r_ret_miss <= w_miss;
        end
    end
`endif

endmodule : pc_gen
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_gen
//  Description : Scoreboard bench for pc_gen. A driver applies directed
//                vectors before each falling edge and queues the expected
//                state; a monitor compares after each falling edge. A second
//                16-bit instance exercises address wrap-around. Expected
//                values adapt to whether PC_RAS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

`ifdef PC_RAS_EN
    localparam bit c_ras = 1'b1;
`else
    localparam bit c_ras = 1'b0;
`endif

    typedef struct {
        bit          w16;
        logic [31:0] pc;
        logic [2:0]  cnt;
        logic        miss;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hit = 1'b0;
    logic        exception = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic [2:0]  ras_count;
    logic        ret_miss;

    logic        h_hit = 1'b0;
    logic        h_rv = 1'b0;
    logic [15:0] h_tgt = '0;
    logic        h_zero = 1'b0;
    logic [15:0] h_pc;
    logic [15:0] h_pc_plus;
    logic [2:0]  h_ras_count;
    logic        h_ret_miss;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk             (clk),
        .rst             (rst),
        .hit             (hit),
        .exception       (exception),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .call            (call),
        .ret             (ret),
        .pc              (pc),
        .pc_plus         (pc_plus),
        .ras_count       (ras_count),
        .ret_miss        (ret_miss)
    );

    pc_gen #(
        .WIDTH     (16),
        .RESET_VEC (16'h0000),
        .EXC_VEC   (16'h0080)
    ) dut16 (
        .clk             (clk),
        .rst             (rst),
        .hit             (h_hit),
        .exception       (h_zero),
        .redirect_valid  (h_rv),
        .redirect_target (h_tgt),
        .call            (h_zero),
        .ret             (h_zero),
        .pc              (h_pc),
        .pc_plus         (h_pc_plus),
        .ras_count       (h_ras_count),
        .ret_miss        (h_ret_miss)
    );

    function automatic logic [31:0] r(input logic [31:0] with_ras, input logic [31:0] without);
        return c_ras ? with_ras : without;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: state is settled 1 time unit after each falling edge.
    initial begin
        exp_t        e;
        logic [15:0] p16;
        forever begin
            @(negedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.w16) begin
                    p16 = e.pc[15:0] + 16'd4;
                    cmp({e.name, ".pc"},       {16'h0, h_pc},      e.pc);
                    cmp({e.name, ".pc_plus"},  {16'h0, h_pc_plus}, {16'h0, p16});
                    cmp({e.name, ".count"},    {29'h0, h_ras_count}, {29'h0, e.cnt});
                    cmp({e.name, ".ret_miss"}, {31'h0, h_ret_miss},  {31'h0, e.miss});
                end else begin
                    cmp({e.name, ".pc"},       pc,                   e.pc);
                    cmp({e.name, ".pc_plus"},  pc_plus,              e.pc + 32'd4);
                    cmp({e.name, ".count"},    {29'h0, ras_count},   {29'h0, e.cnt});
                    cmp({e.name, ".ret_miss"}, {31'h0, ret_miss},    {31'h0, e.miss});
                end
            end
        end
    end

    // Driver: apply inputs at the rising edge, queue what the next falling
    // edge must produce.
    task automatic t(input logic h, input logic c, input logic rt, input logic rv,
                     input logic [31:0] tgt, input logic ex, input logic [31:0] epc,
                     input logic [31:0] ecnt, input logic emiss, input string nm);
        @(posedge clk);
        hit = h; call = c; ret = rt; redirect_valid = rv;
        redirect_target = tgt; exception = ex;
        h_hit = 1'b0; h_rv = 1'b0;
        q.push_back('{w16: 1'b0, pc: epc, cnt: ecnt[2:0], miss: emiss, name: nm});
    endtask

    task automatic t16(input logic h, input logic rv, input logic [15:0] tgt,
                       input logic [31:0] epc, input string nm);
        @(posedge clk);
        hit = 1'b0; call = 1'b0; ret = 1'b0; redirect_valid = 1'b0; exception = 1'b0;
        h_hit = h; h_rv = rv; h_tgt = tgt;
        q.push_back('{w16: 1'b1, pc: epc, cnt: 3'd0, miss: 1'b0, name: nm});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state, sequential advance, stall
        t(0,0,0,0,0,0, 32'h0, 0, 0, "reset");
        t(1,0,0,0,0,0, 32'h4, 0, 0, "seq1");
        t(1,0,0,0,0,0, 32'h8, 0, 0, "seq2");
        t(1,0,0,0,0,0, 32'hC, 0, 0, "seq3");
        t(0,0,0,0,0,0, 32'hC, 0, 0, "stall1");
        t(0,0,0,0,0,0, 32'hC, 0, 0, "stall2");
        t(1,0,0,0,0,0, 32'h10, 0, 0, "seq4");

        // Call, redirect, return
        t(1,1,0,0,0,0, 32'h14, r(1,0), 0, "call");
        t(0,0,0,1,32'h200,0, 32'h200, r(1,0), 0, "redir");
        t(1,0,1,0,0,0, r(32'h14,32'h204), 0, 0, "ret");

        // Fill past depth, drain, then underflow
        t(0,0,0,1,32'h0,0, 32'h0, 0, 0, "redir0");
        for (int i = 0; i < 5; i++)
            t(1,1,0,0,0,0, 32'(4*(i+1)), r((i < 4) ? 32'(i+1) : 32'd4, 0), 0,
              $sformatf("fill%0d", i));
        for (int i = 0; i < 4; i++)
            t(1,0,1,0,0,0, r(32'(32'h14 - 4*i), 32'(32'h18 + 4*i)), r(32'(3-i), 0), 0,
              $sformatf("drain%0d", i));
        t(1,0,1,0,0,0, r(32'hC, 32'h28), 0, r(1,0) != 0, "ret_empty");
        t(1,0,0,0,0,0, r(32'h10, 32'h2C), 0, 0, "miss_clear");

        // Priority: exception over redirect over return
        t(0,0,0,1,32'h100,0, 32'h100, 0, 0, "redir100");
        t(1,1,0,0,0,0, 32'h104, r(1,0), 0, "call104");
        t(1,0,1,1,32'h300,1, 32'h80, r(1,0), 0, "prio_exc");
        t(1,1,1,1,32'h300,0, 32'h300, r(1,0), 0, "prio_redir");
        t(1,0,1,0,0,0, r(32'h104, 32'h304), 0, 0, "prio_pop");

        // Simultaneous call and return
        t(0,0,0,1,32'h20,0, 32'h20, 0, 0, "redir20");
        t(1,1,0,0,0,0, 32'h24, r(1,0), 0, "call24");
        t(0,0,0,1,32'h40,0, 32'h40, r(1,0), 0, "redir40");
        t(1,1,1,0,0,0, r(32'h24, 32'h44), r(1,0), 0, "callret");
        t(1,0,1,0,0,0, r(32'h44, 32'h48), 0, 0, "callret_top");
        t(1,1,1,0,0,0, r(32'h48, 32'h4C), r(1,0), r(1,0) != 0, "callret_empty");
        t(1,0,1,0,0,0, r(32'h48, 32'h50), 0, 0, "callret_pop");

        // Asynchronous reset between edges, during a stall
        t(0,0,0,1,32'hFFC,0, 32'hFFC, 0, 0, "redirFFC");
        t(1,1,0,0,0,0, 32'h1000, r(1,0), 0, "call1000");
        t(0,0,0,0,0,0, 32'h0, 0, 0, "post_rst");
        #2 rst = 1'b1;
        #1;
        cmp("async_rst.pc", pc, 32'h0);
        cmp("async_rst.count", {29'h0, ras_count}, 32'h0);
        #1 rst = 1'b0;
        t(1,0,0,0,0,0, 32'h4, 0, 0, "after_rst");

        // 16-bit wrap
        t16(0,1,16'hFFFC, 32'hFFFC, "w16_redir");
        t16(1,0,16'h0,    32'h0000, "w16_wrap");
        t16(1,0,16'h0,    32'h0004, "w16_seq");

        @(posedge clk);
        h_hit = 1'b0; h_rv = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #3;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pc_gen
`default_nettype wire
